// File: rtl/clock_reset_seq_if.sv
// Handshake bundle for the reset/clock-enable sequencer.
// The master side drives the PLL lock flag and the user reset request.
// The slave side (the sequencer) drives the system reset and the phase enables.
interface clock_reset_seq_if;
  logic locked;
  logic rst_req;
  logic sys_reset_n;
  logic ready;
  logic ce_14m;
  logic ce_7m_p;
  logic ce_7m_n;
  logic ce_3m5_p;
  logic ce_3m5_n;

  modport master (
    output locked, rst_req,
    input  sys_reset_n, ready, ce_14m, ce_7m_p, ce_7m_n, ce_3m5_p, ce_3m5_n
  );

  modport slave (
    input  locked, rst_req,
    output sys_reset_n, ready, ce_14m, ce_7m_p, ce_7m_n, ce_3m5_p, ce_3m5_n
  );
endinterface

// File: rtl/clock_reset_seq.sv
// Reset / clock-enable sequencer downstream of the system PLL.
// - Holds the system in reset until the PLL lock flag has been stable for
//   STABLE_CYCLES.
// - Stretches a user reset request to at least USER_RST_CYCLES.
// - In RUN, emits phase-aligned 14 / 7 / 3.5 MHz enables from a 4-bit
//   divider that always restarts at 0 on entry to RUN.
// All outputs are registered from next-state values, so they change on the
// same edge as the state register.
module clock_reset_seq #(
  parameter int STABLE_CYCLES   = 4096,
  parameter int USER_RST_CYCLES = 256
) (
  input  logic               clock,
  input  logic               reset,
  clock_reset_seq_if.slave   bus
);

  localparam int MAXC = (STABLE_CYCLES > USER_RST_CYCLES) ? STABLE_CYCLES : USER_RST_CYCLES;
  localparam int CW   = (MAXC > 2) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] USR_LAST = CW'(USER_RST_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    RUN       = 2'd2,
    USER_RST  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [3:0]    div, div_d;
  logic          lock_m, lock_s;
  logic          run_d;

  // Two-flop synchroniser; raw locked is sampled nowhere else.
  always_ff @(posedge clock) begin
    if (!reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= bus.locked;
      lock_s <= lock_m;
    end
  end

  // State, counter and divider registers.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= WAIT_LOCK;
      cnt   <= '0;
      div   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      div   <= div_d;
    end
  end

  // Next-state logic; lock loss wins over everything in every state.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABILIZE;
          cnt_d   = '0;
        end
      end
      STABILIZE: begin
        if (!lock_s)               state_d = WAIT_LOCK;
        else if (cnt == STB_LAST)  state_d = RUN;
        else                       cnt_d   = cnt + 1'b1;
      end
      RUN: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (bus.rst_req) begin
          state_d = USER_RST;
          cnt_d   = '0;
        end
      end
      USER_RST: begin
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else begin
          // Count saturates so a held request keeps the system in reset.
          if (cnt >= USR_LAST && !bus.rst_req) state_d = RUN;
          if (cnt < USR_LAST)                  cnt_d   = cnt + 1'b1;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  // Divider runs only while staying in RUN, so every RUN entry starts at 0.
  always_comb begin
    run_d = (state_d == RUN);
    div_d = (run_d && state == RUN) ? div + 4'd1 : 4'd0;
  end

  // Registered outputs decoded from the values the registers will hold.
  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.sys_reset_n <= 1'b0;
      bus.ready       <= 1'b0;
      bus.ce_14m      <= 1'b0;
      bus.ce_7m_p     <= 1'b0;
      bus.ce_7m_n     <= 1'b0;
      bus.ce_3m5_p    <= 1'b0;
      bus.ce_3m5_n    <= 1'b0;
    end else begin
      bus.sys_reset_n <= run_d;
      bus.ready       <= run_d;
      bus.ce_14m      <= run_d && (div_d[1:0] == 2'd3);
      bus.ce_7m_p     <= run_d && (div_d[2:0] == 3'd3);
      bus.ce_7m_n     <= run_d && (div_d[2:0] == 3'd7);
      bus.ce_3m5_p    <= run_d && (div_d == 4'd7);
      bus.ce_3m5_n    <= run_d && (div_d == 4'd15);
    end
  end

endmodule

// File: tb/tb_clock_reset_seq.sv
// Bench for clock_reset_seq with STABLE_CYCLES=16, USER_RST_CYCLES=8.
// Stimulus pushes the expected sys_reset_n transitions (value, edge index)
// into a queue; a negedge monitor pops one per observed transition.
module tb_clock_reset_seq;
  localparam int S = 16;
  localparam int U = 8;

  typedef struct {
    logic val;
    int   cy;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic prev = 1'b0;
  exp_t q[$];
  exp_t mon_e;
  int   cnt_ce[5];
  int   first_ce[5];

  clock_reset_seq_if bus();

  clock_reset_seq #(.STABLE_CYCLES(S), .USER_RST_CYCLES(U)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [4:0] ces();
    return {bus.ce_14m, bus.ce_7m_p, bus.ce_7m_n, bus.ce_3m5_p, bus.ce_3m5_n};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic push(input logic v, input int c);
    exp_t e;
    e.val = v;
    e.cy  = c;
    q.push_back(e);
  endtask

  // Count enables over n cycles starting at the current negedge.
  // Index: 0=ce_14m 1=ce_7m_p 2=ce_7m_n 3=ce_3m5_p 4=ce_3m5_n.
  task automatic win(input int n);
    int g;
    logic [4:0] v;
    g = cyc;
    for (int b = 0; b < 5; b++) begin
      cnt_ce[b]   = 0;
      first_ce[b] = -1;
    end
    for (int i = 0; i < n; i++) begin
      v = ces();
      for (int b = 0; b < 5; b++) begin
        if (v[4-b]) begin
          cnt_ce[b]++;
          if (first_ce[b] < 0) first_ce[b] = cyc - g;
        end
      end
      tick(1);
    end
  endtask

  // Monitor: ready tracks sys_reset_n, no enable in reset, transitions scored.
  always @(negedge clock) begin
    checks++;
    if (bus.ready !== bus.sys_reset_n) begin
      errors++;
      $display("FAIL ready_eq: ready=%b sys_reset_n=%b cycle %0d", bus.ready, bus.sys_reset_n, cyc);
    end
    checks++;
    if (bus.sys_reset_n !== 1'b1 && ces() !== 5'b0) begin
      errors++;
      $display("FAIL ce_in_reset: ces=%b cycle %0d", ces(), cyc);
    end
    if (bus.sys_reset_n !== prev) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_edge: sys_reset_n=%b at cycle %0d, none expected", bus.sys_reset_n, cyc);
      end else begin
        mon_e = q.pop_front();
        if (mon_e.val !== bus.sys_reset_n || mon_e.cy != cyc) begin
          errors++;
          $display("FAIL rst_edge: got %b at cycle %0d want %b at cycle %0d",
                   bus.sys_reset_n, cyc, mon_e.val, mon_e.cy);
        end
      end
      prev = bus.sys_reset_n;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.locked  = 1'b1;
    bus.rst_req = 1'b0;
    reset       = 1'b0;

    // 1: reset held 5 cycles with lock present, then release
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      chk("reset_outs", {bus.sys_reset_n, bus.ready, ces()}, 0);
      tick(1);
    end
    reset = 1'b1;
    k = cyc;
    push(1'b1, k + 19);
    to_cyc(k + 19);

    // 3: enable counts and phases over 64 RUN cycles
    win(64);
    chk("cnt_14m",   cnt_ce[0], 16);
    chk("cnt_7m_p",  cnt_ce[1], 8);
    chk("cnt_7m_n",  cnt_ce[2], 8);
    chk("cnt_3m5_p", cnt_ce[3], 4);
    chk("cnt_3m5_n", cnt_ce[4], 4);
    chk("first_14m",   first_ce[0], 3);
    chk("first_7m_p",  first_ce[1], 3);
    chk("first_7m_n",  first_ce[2], 7);
    chk("first_3m5_p", first_ce[3], 7);
    chk("first_3m5_n", first_ce[4], 15);

    // 4a: one-cycle user request -> exactly 8 cycles low
    k = cyc;
    bus.rst_req = 1'b1;
    push(1'b0, k + 1);
    tick(1);
    bus.rst_req = 1'b0;
    push(1'b1, k + 9);
    to_cyc(k + 12);

    // 4b: request held 20 cycles -> low 20 cycles, divider restarts
    k = cyc;
    bus.rst_req = 1'b1;
    push(1'b0, k + 1);
    tick(20);
    bus.rst_req = 1'b0;
    push(1'b1, k + 21);
    to_cyc(k + 21);
    win(16);
    chk("ur_cnt_14m",    cnt_ce[0], 4);
    chk("ur_first_14m",  first_ce[0], 3);
    chk("ur_first_7m_n", first_ce[2], 7);
    chk("ur_first_3m5_p", first_ce[3], 7);
    chk("ur_first_3m5_n", first_ce[4], 15);

    // lock loss in RUN: sys_reset_n falls 3 edges later
    k = cyc;
    bus.locked = 1'b0;
    push(1'b0, k + 3);
    tick(6);

    // 2: 10-cycle lock, 3-cycle drop, relock -> full count from second rise
    bus.locked = 1'b1;
    tick(10);
    bus.locked = 1'b0;
    tick(3);
    k = cyc;
    bus.locked = 1'b1;
    push(1'b1, k + 19);
    to_cyc(k + 21);

    // 5: lock dropped during USER_RST -> WAIT_LOCK, full restabilisation
    k = cyc;
    bus.rst_req = 1'b1;
    push(1'b0, k + 1);
    tick(3);
    bus.locked  = 1'b0;
    bus.rst_req = 1'b0;
    tick(6);
    k = cyc;
    bus.locked = 1'b1;
    push(1'b1, k + 19);
    to_cyc(k + 21);

    // 6: reset asserted mid-STABILIZE at cnt=9 -> count restarts
    k = cyc;
    bus.locked = 1'b0;
    push(1'b0, k + 3);
    tick(6);
    bus.locked = 1'b1;
    tick(12);
    reset = 1'b0;
    tick(1);
    chk("mid_reset_outs_a", {bus.sys_reset_n, bus.ready, ces()}, 0);
    tick(1);
    chk("mid_reset_outs_b", {bus.sys_reset_n, bus.ready, ces()}, 0);
    reset = 1'b1;
    k = cyc;
    push(1'b1, k + 19);
    to_cyc(k + 22);

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
